// File: rtl/regfile_pkg.sv
// Shared defaults and sizing helpers for the bypassed register file.
package regfile_pkg;

  localparam int unsigned DefDataW = 64;
  localparam int unsigned DefAddrW = 5;

  // Bits needed to count 0..2**addrW set entries.
  function automatic int unsigned popWidth(input int unsigned addrW);
    return addrW + 1;
  endfunction

endpackage

// File: rtl/regfile_bypass_load_scoreboard.sv
// Load scoreboard: per-register busy bits, read hazards, busy count and
// sticky protocol-violation flag.
module load_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter bit          ZERO_EN  = 1'b1,
  parameter int unsigned ZERO_IDX = 2**ADDR_W - 1,
  localparam int unsigned CNT_W   = popWidth(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWr,
  input  logic [ADDR_W-1:0] rw,
  input  logic              ldWr,
  input  logic [ADDR_W-1:0] ldRW,
  input  logic              ldIssue,
  input  logic [ADDR_W-1:0] ldRd,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic              hazardA_c,
  output logic              hazardB_c,
  output logic [CNT_W-1:0]  pendCnt,
  output logic              protErr
);

  localparam int unsigned       DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_IDX);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busyNext;
  logic [CNT_W-1:0] pendNext;
  logic             errNext;
  logic             issueEff;
  logic             clrEff;
  logic             sameReg;
  logic             incr;
  logic             decr;
  logic             violation;

  function automatic logic isZero(input logic [ADDR_W-1:0] a);
    return ZERO_EN && (a == ZeroAddr);
  endfunction

  // Next busy vector, count delta and violation detection.
  always_comb begin
    issueEff  = ldIssue && !isZero(ldRd);
    clrEff    = ldWr && !isZero(ldRW);
    sameReg   = (ldRd == ldRW);
    busyNext  = busy;
    pendNext  = pendCnt;
    errNext   = protErr;

    // A same-cycle issue overrides the clear of the same register.
    if (clrEff) begin
      busyNext[ldRW] = 1'b0;
    end
    if (issueEff) begin
      busyNext[ldRd] = 1'b1;
    end

    // Count tracks the popcount incrementally: at most one bit rises and one falls.
    incr = issueEff && !busy[ldRd];
    decr = clrEff && busy[ldRW] && !(issueEff && sameReg);
    if (incr && !decr) begin
      pendNext = pendCnt + CNT_W'(1);
    end else if (decr && !incr) begin
      pendNext = pendCnt - CNT_W'(1);
    end

    violation = (clrEff && !busy[ldRW])
             || (issueEff && busy[ldRd] && !(clrEff && sameReg))
             || (regWr && busy[rw]);
    if (violation) begin
      errNext = 1'b1;
    end
  end

  // Scoreboard state; reset drops any outstanding loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= '0;
      pendCnt <= '0;
      protErr <= 1'b0;
    end else begin
      busy    <= busyNext;
      pendCnt <= pendNext;
      protErr <= errNext;
    end
  end

  // A returning load this cycle resolves the hazard through the bypass path.
  always_comb begin
    hazardA_c = busy[ra] && !(ldWr && (ldRW == ra));
    hazardB_c = busy[rb] && !(ldWr && (ldRW == rb));
  end

endmodule

// File: rtl/regfile_bypass.sv
// Two-read, two-write register file with write-to-read bypass, optional
// hard-wired zero register and a load scoreboard.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter bit          ZERO_EN  = 1'b1,
  parameter int unsigned ZERO_IDX = 2**ADDR_W - 1,
  localparam int unsigned CNT_W   = popWidth(ADDR_W)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB,
  input  logic              RegWr,
  input  logic [ADDR_W-1:0] RW,
  input  logic [DATA_W-1:0] BusW,
  input  logic              LdWr,
  input  logic [ADDR_W-1:0] LdRW,
  input  logic [DATA_W-1:0] LdBusW,
  input  logic              LdIssue,
  input  logic [ADDR_W-1:0] LdRd,
  output logic              HazardA,
  output logic              HazardB,
  output logic [CNT_W-1:0]  PendCnt,
  output logic              ProtErr
);

  localparam int unsigned       DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr0;
  logic              wr1;

  function automatic logic isZero(input logic [ADDR_W-1:0] a);
    return ZERO_EN && (a == ZeroAddr);
  endfunction

  // Port 0 has priority over port 1 for storage and bypass.
  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] a);
    if (isZero(a)) begin
      return '0;
    end else if (wr0 && (RW == a)) begin
      return BusW;
    end else if (wr1 && (LdRW == a)) begin
      return LdBusW;
    end
    return regs[a];
  endfunction

  // Effective write enables with the zero register filtered out.
  always_comb begin
    wr0 = RegWr && !isZero(RW);
    wr1 = LdWr && !isZero(LdRW);
  end

  // Storage array; the later port-0 assignment wins on an address collision.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      regs <= '{default: '0};
    end else begin
      if (wr1) begin
        regs[LdRW] <= LdBusW;
      end
      if (wr0) begin
        regs[RW] <= BusW;
      end
    end
  end

  // Zero-latency read ports with same-cycle bypass.
  always_comb begin
    BusA = readPort(RA);
    BusB = readPort(RB);
  end

  load_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_EN (ZERO_EN),
    .ZERO_IDX(ZERO_IDX)
  ) uScoreboard (
    .clk      (Clk),
    .rst      (Reset),
    .regWr    (RegWr),
    .rw       (RW),
    .ldWr     (LdWr),
    .ldRW     (LdRW),
    .ldIssue  (LdIssue),
    .ldRd     (LdRd),
    .ra       (RA),
    .rb       (RB),
    .hazardA_c(HazardA),
    .hazardB_c(HazardB),
    .pendCnt  (PendCnt),
    .protErr  (ProtErr)
  );

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: one instance with the zero register disabled
// (index 0) and one with it enabled (index 1), both driven identically and
// compared against an array-based reference model.
module tb_regfile_bypass;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  RA, RB, RW, LdRW, LdRd;
  logic        RegWr, LdWr, LdIssue;
  logic [63:0] BusW, LdBusW;

  logic [63:0] busA [2];
  logic [63:0] busB [2];
  logic        hazA [2];
  logic        hazB [2];
  logic [5:0]  pendCnt [2];
  logic        protErr [2];

  int checks = 0;
  int errors = 0;

  // Reference state per instance.
  logic [63:0] mMem  [2][32];
  bit          mBusy [2][32];
  bit          mErr  [2];

  always #5 Clk = ~Clk;

  regfile_bypass #(.DATA_W(64), .ADDR_W(5), .ZERO_EN(1'b0), .ZERO_IDX(31)) dut0 (
    .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .BusA(busA[0]), .BusB(busB[0]),
    .RegWr(RegWr), .RW(RW), .BusW(BusW), .LdWr(LdWr), .LdRW(LdRW), .LdBusW(LdBusW),
    .LdIssue(LdIssue), .LdRd(LdRd), .HazardA(hazA[0]), .HazardB(hazB[0]),
    .PendCnt(pendCnt[0]), .ProtErr(protErr[0])
  );

  regfile_bypass #(.DATA_W(64), .ADDR_W(5), .ZERO_EN(1'b1), .ZERO_IDX(31)) dut1 (
    .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .BusA(busA[1]), .BusB(busB[1]),
    .RegWr(RegWr), .RW(RW), .BusW(BusW), .LdWr(LdWr), .LdRW(LdRW), .LdBusW(LdBusW),
    .LdIssue(LdIssue), .LdRd(LdRd), .HazardA(hazA[1]), .HazardB(hazB[1]),
    .PendCnt(pendCnt[1]), .ProtErr(protErr[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit isZ(input int z, input logic [4:0] a);
    return (z == 1) && (a == 5'd31);
  endfunction

  function automatic logic [63:0] expRead(input int z, input logic [4:0] a);
    if (isZ(z, a)) return 64'd0;
    if (RegWr && RW == a) return BusW;
    if (LdWr && LdRW == a) return LdBusW;
    return mMem[z][a];
  endfunction

  function automatic logic expHaz(input int z, input logic [4:0] a);
    return mBusy[z][a] && !(LdWr && LdRW == a);
  endfunction

  function automatic logic [63:0] expCnt(input int z);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(mBusy[z][i]);
    return 64'(c);
  endfunction

  task automatic clearModel();
    for (int z = 0; z < 2; z++) begin
      mErr[z] = 1'b0;
      for (int i = 0; i < 32; i++) begin
        mMem[z][i]  = 64'd0;
        mBusy[z][i] = 1'b0;
      end
    end
  endtask

  // Apply one clock edge of the rules to the model.
  task automatic modelEdge();
    for (int z = 0; z < 2; z++) begin
      bit issue, clr, wr0;
      issue = LdIssue && !isZ(z, LdRd);
      clr   = LdWr && !isZ(z, LdRW);
      wr0   = RegWr && !isZ(z, RW);
      if (clr && !mBusy[z][LdRW]) mErr[z] = 1'b1;
      if (issue && mBusy[z][LdRd] && !(clr && LdRW == LdRd)) mErr[z] = 1'b1;
      if (RegWr && mBusy[z][RW]) mErr[z] = 1'b1;
      if (clr) mMem[z][LdRW] = LdBusW;
      if (wr0) mMem[z][RW] = BusW;
      if (clr) mBusy[z][LdRW] = 1'b0;
      if (issue) mBusy[z][LdRd] = 1'b1;
    end
  endtask

  task automatic checkAll(input string tag);
    for (int z = 0; z < 2; z++) begin
      chk($sformatf("%s/z%0d/BusA", tag, z), busA[z], expRead(z, RA));
      chk($sformatf("%s/z%0d/BusB", tag, z), busB[z], expRead(z, RB));
      chk($sformatf("%s/z%0d/HazardA", tag, z), 64'(hazA[z]), 64'(expHaz(z, RA)));
      chk($sformatf("%s/z%0d/HazardB", tag, z), 64'(hazB[z]), 64'(expHaz(z, RB)));
      chk($sformatf("%s/z%0d/PendCnt", tag, z), 64'(pendCnt[z]), expCnt(z));
      chk($sformatf("%s/z%0d/ProtErr", tag, z), 64'(protErr[z]), 64'(mErr[z]));
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    #1 checkAll(tag);
    @(posedge Clk);
    modelEdge();
    @(negedge Clk);
  endtask

  task automatic idle();
    RegWr = 1'b0; RW = 5'd0; BusW = 64'd0;
    LdWr = 1'b0; LdRW = 5'd0; LdBusW = 64'd0;
    LdIssue = 1'b0; LdRd = 5'd0;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    clearModel();
    #1 checkAll("reset");
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  function automatic logic [4:0] rAddr();
    int r = int'($urandom_range(0, 9));
    return (r >= 8) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    idle();
    RA = 5'd0; RB = 5'd0;
    Reset = 1'b0;
    clearModel();
    #2 Reset = 1'b1;
    #1 checkAll("por");
    chk("por_pend", 64'(pendCnt[1]), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Same-cycle bypass then stored value.
    RegWr = 1'b1; RW = 5'd5; BusW = 64'hDEAD; RA = 5'd5;
    #1 chk("s32_bypass", busA[1], 64'hDEAD);
    cycle("s32w");
    idle();
    #1 chk("s32_stored", busA[1], 64'hDEAD);
    cycle("s32r");

    // Zero register versus ordinary register 31.
    RegWr = 1'b1; RW = 5'd31; BusW = 64'h1234; RA = 5'd31;
    #1 chk("s33_zero_byp", busA[1], 64'd0);
    chk("s33_plain_byp", busA[0], 64'h1234);
    cycle("s33w");
    idle();
    #1 chk("s33_zero_rd", busA[1], 64'd0);
    chk("s33_plain_rd", busA[0], 64'h1234);
    cycle("s33r");

    // Populate 3 and 7, leave a load outstanding on 6, then reset mid-cycle.
    RegWr = 1'b1; RW = 5'd3; BusW = 64'hAAA;
    cycle("pre1");
    RW = 5'd7; BusW = 64'hBBB; LdIssue = 1'b1; LdRd = 5'd6;
    cycle("pre2");
    idle();
    RA = 5'd3; RB = 5'd7;
    #1 chk("pre_busA", busA[1], 64'hAAA);
    chk("pre_pend", 64'(pendCnt[1]), 64'd1);
    #1 Reset = 1'b1;
    clearModel();
    #1 chk("s31_busA", busA[1], 64'd0);
    chk("s31_busB", busB[1], 64'd0);
    chk("s31_pend", 64'(pendCnt[1]), 64'd0);
    chk("s31_err", 64'(protErr[1]), 64'd0);
    checkAll("s31");
    @(negedge Clk);
    Reset = 1'b0;

    // Load that was outstanding at reset returns.
    LdWr = 1'b1; LdRW = 5'd6; LdBusW = 64'h66; RA = 5'd6;
    cycle("s27w");
    idle();
    #1 chk("s27_err", 64'(protErr[1]), 64'd1);
    chk("s27_data", busA[1], 64'h66);
    doReset();

    // Issue, hazard, return with bypass, count drop.
    LdIssue = 1'b1; LdRd = 5'd9;
    cycle("s34i");
    idle();
    RA = 5'd9;
    #1 chk("s34_haz", 64'(hazA[1]), 64'd1);
    chk("s34_pend", 64'(pendCnt[1]), 64'd1);
    cycle("s34h");
    LdWr = 1'b1; LdRW = 5'd9; LdBusW = 64'h55;
    #1 chk("s34_haz_clr", 64'(hazA[1]), 64'd0);
    chk("s34_byp", busA[1], 64'h55);
    cycle("s34w");
    idle();
    #1 chk("s34_pend0", 64'(pendCnt[1]), 64'd0);
    chk("s34_noerr", 64'(protErr[1]), 64'd0);
    cycle("s34d");

    // Issue and return on the same register in one cycle keeps it busy.
    LdIssue = 1'b1; LdRd = 5'd12;
    cycle("s20a");
    LdWr = 1'b1; LdRW = 5'd12; LdBusW = 64'hC;
    cycle("s20b");
    idle();
    RA = 5'd12;
    #1 chk("s20_haz", 64'(hazA[1]), 64'd1);
    chk("s20_pend", 64'(pendCnt[1]), 64'd1);
    chk("s20_noerr", 64'(protErr[1]), 64'd0);
    LdWr = 1'b1; LdRW = 5'd12; LdBusW = 64'hD;
    cycle("s20c");
    idle();

    // Both ports hit busy register 4.
    doReset();
    LdIssue = 1'b1; LdRd = 5'd4;
    cycle("s35i");
    idle();
    RegWr = 1'b1; RW = 5'd4; BusW = 64'h11;
    LdWr = 1'b1; LdRW = 5'd4; LdBusW = 64'h22; RA = 5'd4;
    #1 chk("s35_byp", busA[1], 64'h11);
    cycle("s35w");
    idle();
    #1 chk("s35_stored", busA[1], 64'h11);
    chk("s35_err", 64'(protErr[1]), 64'd1);
    chk("s35_pend", 64'(pendCnt[1]), 64'd0);
    chk("s35_haz", 64'(hazA[1]), 64'd0);
    cycle("s35r");

    // Stray load return is written and the error sticks until reset.
    doReset();
    LdWr = 1'b1; LdRW = 5'd2; LdBusW = 64'h77; RA = 5'd2;
    cycle("s36w");
    idle();
    for (int i = 0; i < 10; i++) begin
      #1 chk($sformatf("s36_err%0d", i), 64'(protErr[1]), 64'd1);
      chk($sformatf("s36_data%0d", i), busA[1], 64'h77);
      cycle("s36h");
    end
    doReset();
    #1 chk("s36_cleared", 64'(protErr[1]), 64'd0);

    // Randomized traffic over a small address set to force collisions.
    for (int k = 0; k < 400; k++) begin
      if (k % 100 == 99) begin
        idle();
        doReset();
      end else begin
        RegWr   = ($urandom_range(0, 2) == 0);
        RW      = rAddr();
        BusW    = {$urandom, $urandom};
        LdWr    = ($urandom_range(0, 2) == 0);
        LdRW    = rAddr();
        LdBusW  = {$urandom, $urandom};
        LdIssue = ($urandom_range(0, 2) == 0);
        LdRd    = rAddr();
        RA      = rAddr();
        RB      = rAddr();
        cycle("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
